uart_fifo_ctrl: RTL

Parametrised bus-attached UART controller, the successor to the fixed single-byte `uart_top`. It adds TX/RX FIFOs of configurable depth, a runtime baud divisor, configurable data width, optional parity, sticky error flags and an interrupt output. It keeps the existing register map: RECV at 0x4, SEND at 0x8 and STATUS at 0xC, with STATUS bit0 meaning TX ready and bit1 meaning RX available. The block sits on the CPU peripheral bus in the single `clk_bus` domain.

---
 rtl/uart_fifo_ctrl.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_ctrl.sv
// Bus-attached UART with TX/RX FIFOs, runtime baud divisor, optional parity,
// sticky error flags and a level interrupt. Single clock domain (clk_bus).
module uart_fifo_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 26
) (
    input  logic        clk_bus,
    input  logic        rst_n,
    input  logic [3:0]  bus_address,
    input  logic [31:0] bus_data_i,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic [31:0] bus_data_o,
    output logic        txd,
    input  logic        rxd,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    logic [15:0] div;
    logic        par_en, par_odd, ie_rx, ie_tx, ie_err;
    logic        rx_ovr, par_err, frm_err, tx_ovf;

    logic wr_ctrl, wr_send, wr_stat, rd_recv;
    assign wr_ctrl = bus_write && bus_address == 4'h0;
    assign wr_send = bus_write && bus_address == 4'h8;
    assign wr_stat = bus_write && bus_address == 4'hC;
    assign rd_recv = bus_read  && bus_address == 4'h4;

    logic unused_bits;
    assign unused_bits = ^bus_data_i[31:21];

    // ---------------- FIFOs ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0]        tx_cnt, rx_cnt;
    logic                 tx_full, tx_empty, rx_full, rx_empty;
    logic                 tx_push, tx_pop, rx_push_ok, rx_pop;
    logic                 rx_push;
    logic [DATA_BITS-1:0] rx_sh, tx_head;

    assign tx_full    = tx_cnt == FULL_CNT;
    assign tx_empty   = tx_cnt == '0;
    assign rx_full    = rx_cnt == FULL_CNT;
    assign rx_empty   = rx_cnt == '0;
    assign tx_push    = wr_send && !tx_full;
    assign rx_push_ok = rx_push && !rx_full;
    assign rx_pop     = rd_recv && !rx_empty;
    assign tx_head    = tx_mem[tx_rp];

    always_ff @(posedge clk_bus) begin
        if (tx_push)    tx_mem[tx_wp] <= bus_data_i[DATA_BITS-1:0];
        if (rx_push_ok) rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
            rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
        end else begin
            if (tx_push)    tx_wp <= tx_wp + 1'b1;
            if (tx_pop)     tx_rp <= tx_rp + 1'b1;
            if (rx_push_ok) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)     rx_rp <= rx_rp + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: ;
            endcase
            case ({rx_push_ok, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- TX ----------------
    tx_state_t            tx_state;
    logic [DATA_BITS-1:0] tx_sh;
    logic [2:0]           tx_bit;
    logic [3:0]           tx_tk;
    logic [15:0]          tx_bcnt;
    logic                 tx_par, tx_tick, tx_idle;

    assign tx_tick = tx_bcnt == div;
    assign tx_idle = tx_empty && tx_state == TX_IDLE;
    // A frame starts immediately from idle, or on the last stop tick when more data waits.
    assign tx_pop  = !tx_empty && (tx_state == TX_IDLE ||
                     (tx_state == TX_STOP && tx_tick && tx_tk == 4'd15));

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n)                 tx_bcnt <= '0;
        else if (wr_ctrl || tx_pop) tx_bcnt <= '0;
        else if (tx_tick)           tx_bcnt <= '0;
        else                        tx_bcnt <= tx_bcnt + 1'b1;
    end

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_sh    <= '0;
            tx_bit   <= '0;
            tx_tk    <= '0;
            tx_par   <= 1'b0;
            txd      <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= TX_START;
            tx_sh    <= tx_head;
            tx_par   <= (^tx_head) ^ par_odd;
            tx_tk    <= '0;
            txd      <= 1'b0;
        end else if (tx_tick && tx_state != TX_IDLE) begin
            if (tx_tk != 4'd15) begin
                tx_tk <= tx_tk + 1'b1;
            end else begin
                tx_tk <= '0;
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                        txd      <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                    end
                    TX_DATA: begin
                        if (tx_bit == LAST_BIT) begin
                            tx_state <= par_en ? TX_PAR : TX_STOP;
                            txd      <= par_en ? tx_par : 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                            txd    <= tx_sh[0];
                            tx_sh  <= tx_sh >> 1;
                        end
                    end
                    TX_PAR: begin
                        tx_state <= TX_STOP;
                        txd      <= 1'b1;
                    end
                    default: begin
                        tx_state <= TX_IDLE;
                        txd      <= 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------- RX ----------------
    rx_state_t   rx_state;
    logic        rx_s1, rx_s, rx_prev, rx_fall, rx_tick;
    logic [2:0]  rx_bit;
    logic [3:0]  rx_tk;
    logic [15:0] rx_bcnt;
    logic        rx_pbit, rx_perr, rx_ferr;

    assign rx_fall = rx_prev && !rx_s;
    assign rx_tick = rx_bcnt == div;

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1; rx_s <= 1'b1; rx_prev <= 1'b1;
        end else begin
            rx_s1 <= rxd; rx_s <= rx_s1; rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n)                                    rx_bcnt <= '0;
        else if (wr_ctrl || (rx_state == RX_IDLE && rx_fall)) rx_bcnt <= '0;
        else if (rx_tick)                              rx_bcnt <= '0;
        else                                           rx_bcnt <= rx_bcnt + 1'b1;
    end

    // The push is registered one cycle after the mid-stop sample.
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_sh    <= '0;
            rx_bit   <= '0;
            rx_tk    <= '0;
            rx_pbit  <= 1'b0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_push  <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_fall) begin
                    rx_state <= RX_START;
                    rx_tk    <= '0;
                end
                RX_START: if (rx_tick) begin
                    if (rx_tk == 4'd7) begin
                        rx_tk    <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tk <= rx_tk + 1'b1;
                    end
                end
                default: if (rx_tick) begin
                    if (rx_tk != 4'd15) begin
                        rx_tk <= rx_tk + 1'b1;
                    end else begin
                        rx_tk <= '0;
                        case (rx_state)
                            RX_DATA: begin
                                rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
                                if (rx_bit == LAST_BIT) rx_state <= par_en ? RX_PAR : RX_STOP;
                                else                    rx_bit   <= rx_bit + 1'b1;
                            end
                            RX_PAR: begin
                                rx_pbit  <= rx_s;
                                rx_state <= RX_STOP;
                            end
                            default: begin
                                rx_push  <= 1'b1;
                                rx_ferr  <= !rx_s;
                                rx_perr  <= par_en && (rx_pbit != ((^rx_sh) ^ par_odd));
                                rx_state <= RX_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // ---------------- registers, flags, irq ----------------
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            div <= 16'(DEFAULT_DIV);
            {par_en, par_odd, ie_rx, ie_tx, ie_err} <= '0;
            {rx_ovr, par_err, frm_err, tx_ovf} <= '0;
            irq <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                div     <= bus_data_i[15:0];
                par_en  <= bus_data_i[16];
                par_odd <= bus_data_i[17];
                ie_rx   <= bus_data_i[18];
                ie_tx   <= bus_data_i[19];
                ie_err  <= bus_data_i[20];
            end
            // Set has priority over write-one-to-clear.
            rx_ovr  <= (rx_ovr  && !(wr_stat && bus_data_i[2])) || (rx_push && rx_full);
            par_err <= (par_err && !(wr_stat && bus_data_i[3])) || (rx_push && rx_perr);
            frm_err <= (frm_err && !(wr_stat && bus_data_i[4])) || (rx_push && rx_ferr);
            tx_ovf  <= (tx_ovf  && !(wr_stat && bus_data_i[5])) || (wr_send && tx_full);
            irq     <= (ie_rx && !rx_empty) || (ie_tx && tx_idle) ||
                       (ie_err && (rx_ovr || par_err || frm_err || tx_ovf));
        end
    end

    always_comb begin
        bus_data_o = '0;
        if (bus_read) begin
            case (bus_address)
                4'h0: bus_data_o = {11'd0, ie_err, ie_tx, ie_rx, par_odd, par_en, div};
                4'h4: if (!rx_empty) bus_data_o[DATA_BITS-1:0] = rx_mem[rx_rp];
                4'hC: bus_data_o = {8'd0, 8'(tx_cnt), 8'(rx_cnt), 1'b0, tx_idle, tx_ovf,
                                    frm_err, par_err, rx_ovr, !rx_empty, !tx_full};
                default: ;
            endcase
        end
    end
endmodule
